trap_ctrl: RTL and testbench

- Interrupt controller sitting directly upstream of the core's `trap` input.
- Collects N external interrupt lines into a pending register, gates them with an enable mask, and raises `trap`.
- Recognises the core's trap-entry store to `TRAP_ADDR` as the acknowledge, and exposes its control registers as a memory-mapped device on the core data bus (`strobe`/`mem_rw`/`d_addr`/`d_data`).
- Service ends when software writes the EOI register.

---
 rtl/trap_ctrl_pkg.sv | 11 +
 rtl/trap_ctrl_prio_enc.sv | 14 +
 rtl/trap_ctrl.sv | 110 +++++++++++
 tb/tb_trap_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: register offsets, FSM states and the default trap-entry address
// shared by the trap_ctrl files.
package trap_ctrl_pkg;
    localparam logic [31:0] TRAP_ADDR   = 32'h0000_1000;
    localparam logic [1:0]  REG_ENABLE  = 2'd0;
    localparam logic [1:0]  REG_PENDING = 2'd1;
    localparam logic [1:0]  REG_CAUSE   = 2'd2;
    localparam logic [1:0]  REG_EOI     = 2'd3;
    localparam int          CAUSE_VALID = 31;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_SVC = 2'd2} state_e;
endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// prio_enc: combinational lowest-index-wins priority encoder.
module prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [4:0]   idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) idx = req[i] ? 5'(i) : idx;
    end
    assign any = |req;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: edge-latched interrupt controller driving the core trap input, with a
// 4-word register block on the data bus. Define TRAP_CTRL_SYNC_EN for a 2-flop irq synchronizer.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int          NIRQ     = 8,
    parameter logic [31:0] BASE     = 32'h0000_2000,
    parameter logic [31:0] ACK_ADDR = TRAP_ADDR
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NIRQ-1:0] irq,
    output logic            trap,
    input  logic            strobe,
    input  logic            mem_rw,
    input  logic [31:0]     d_addr,
    inout  wire  [31:0]     d_data,
    output logic            in_service
);
    state_e          state_q, state_d;
    logic [NIRQ-1:0] enable_q, enable_d, pending_q, pending_d, irq_prev_q, irq_s;
    logic [NIRQ-1:0] rise, active, w1c, ack_clr;
    logic [31:0]     cause_q, cause_d, rd_val;
    logic [4:0]      sel;
    logic            any, ack, hit, reg_wr;
    logic [1:0]      reg_idx;

`ifdef TRAP_CTRL_SYNC_EN
    logic [NIRQ-1:0] irq_meta_q, irq_sync_q;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_meta_q <= '0;
            irq_sync_q <= '0;
        end else begin
            irq_meta_q <= irq;
            irq_sync_q <= irq_meta_q;
        end
    end
    assign irq_s = irq_sync_q;
`else
    assign irq_s = irq;
`endif

    assign hit     = strobe && (d_addr[31:2] == BASE[31:2]);
    assign reg_idx = d_addr[1:0];
    assign ack     = strobe && mem_rw && (d_addr == ACK_ADDR);
    assign reg_wr  = hit && mem_rw && !ack;
    assign rise    = irq_s & ~irq_prev_q;
    assign active  = pending_q & enable_q;
    assign w1c     = (reg_wr && reg_idx == REG_PENDING) ? d_data[NIRQ-1:0] : '0;

    prio_enc #(.N(NIRQ)) u_prio (.req(active), .idx(sel), .any(any));

    // Reads are combinational: the core samples d_data in its strobe cycle.
    assign rd_val = (reg_idx == REG_ENABLE)  ? 32'(enable_q)  :
                    (reg_idx == REG_PENDING) ? 32'(pending_q) :
                    (reg_idx == REG_CAUSE)   ? cause_q        : '0;
    assign d_data = (hit && !mem_rw) ? rd_val : 'z;

    assign trap       = (state_q == S_REQ);
    assign in_service = (state_q == S_SVC);

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        ack_clr  = '0;
        enable_d = (reg_wr && reg_idx == REG_ENABLE) ? d_data[NIRQ-1:0] : enable_q;
        case (state_q)
            S_IDLE: state_d = any ? S_REQ : S_IDLE;
            S_REQ: begin
                if (ack) begin
                    state_d = S_SVC;
                    cause_d = '0;
                    if (any) begin
                        cause_d[CAUSE_VALID] = 1'b1;
                        cause_d[4:0]         = sel;
                        ack_clr              = NIRQ'(1) << sel;
                    end
                end else if (!any) begin
                    state_d = S_IDLE;
                end
            end
            S_SVC: begin
                if (reg_wr && reg_idx == REG_EOI) begin
                    state_d = S_IDLE;
                    cause_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A new edge wins over any clear in the same cycle.
        pending_d = (pending_q & ~w1c & ~ack_clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            enable_q   <= '0;
            pending_q  <= '0;
            cause_q    <= '0;
            irq_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            pending_q  <= pending_d;
            cause_q    <= cause_d;
            irq_prev_q <= irq_s;
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and random stimulus for trap_ctrl, checked by a scoreboard
// against a behavioural model of the interrupt controller.
module tb_trap_ctrl;
    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h0000_2000;
    localparam logic [31:0] ACK  = 32'h0000_1000;

    logic          clk = 0, reset_n = 0, strobe = 0, mem_rw = 0, drv_en = 0;
    logic [N-1:0]  irq = '0;
    logic [31:0]   d_addr = '0, drv_val = '0;
    logic          trap, in_service;
    wire  [31:0]   d_data;
    assign d_data = drv_en ? drv_val : 'z;

    trap_ctrl #(.NIRQ(N), .BASE(BASE), .ACK_ADDR(ACK)) dut (
        .clk(clk), .reset_n(reset_n), .irq(irq), .trap(trap), .strobe(strobe),
        .mem_rw(mem_rw), .d_addr(d_addr), .d_data(d_data), .in_service(in_service)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic mon_on = 0;
    logic [31:0] exp_q[$];

    // Model: phase 0 = no request, 1 = trap requested, 2 = being serviced.
    int          m_phase = 0;
    logic [N-1:0] m_en = '0, m_pend = '0, m_prev = '0, m_s1 = '0, m_s2 = '0;
    logic [31:0] m_cause = '0;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] r);
        if (r == 0) return 32'(m_en);
        if (r == 1) return 32'(m_pend);
        if (r == 2) return m_cause;
        return 0;
    endfunction

    initial forever begin
        logic [N-1:0] src, rise, act, clr;
        logic ackw, regw;
        int k;
        @(posedge clk);
        if (!reset_n) begin
            m_phase = 0; m_en = '0; m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0; m_cause = '0;
        end else begin
`ifdef TRAP_CTRL_SYNC_EN
            src = m_s2; m_s2 = m_s1; m_s1 = irq;
`else
            src = irq;
`endif
            rise = src & ~m_prev;
            m_prev = src;
            act = m_pend & m_en;
            ackw = strobe && mem_rw && d_addr == ACK;
            regw = strobe && mem_rw && !ackw && d_addr[31:2] == BASE[31:2];
            clr = (regw && d_addr[1:0] == 1) ? drv_val[N-1:0] : '0;
            if (m_phase == 1 && ackw) begin
                m_phase = 2;
                if (act != 0) begin
                    k = lowest(act);
                    m_cause = 32'h8000_0000 | 32'(k);
                    clr[k] = 1'b1;
                end else m_cause = 0;
            end else if (m_phase == 1 && act == 0) m_phase = 0;
            else if (m_phase == 0 && act != 0) m_phase = 1;
            else if (m_phase == 2 && regw && d_addr[1:0] == 3) begin
                m_phase = 0;
                m_cause = 0;
            end
            if (regw && d_addr[1:0] == 0) m_en = drv_val[N-1:0];
            m_pend = (m_pend & ~clr) | rise;
        end
    end

    initial forever begin
        logic [31:0] e;
        @(negedge clk);
        if (mon_on) begin
            checks++;
            if (trap !== (m_phase == 1)) begin
                errors++;
                $display("FAIL trap: got %0b exp %0b at %0t", trap, m_phase == 1, $time);
            end
            checks++;
            if (in_service !== (m_phase == 2)) begin
                errors++;
                $display("FAIL in_service: got %0b exp %0b at %0t", in_service, m_phase == 2, $time);
            end
            if (strobe && !mem_rw && d_addr[31:2] == BASE[31:2]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_unexpected: got %h exp none at %0t", d_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (d_data !== e) begin
                        errors++;
                        $display("FAIL read[%0d]: got %h exp %h at %0t", d_addr[1:0], d_data, e, $time);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
        strobe = 0; mem_rw = 0; drv_en = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        strobe = 1; mem_rw = 1; d_addr = a; drv_val = v; drv_en = 1;
        tick();
    endtask

    task automatic rd_exp(input logic [1:0] r, input logic [31:0] e);
        exp_q.push_back(e);
        strobe = 1; mem_rw = 0; d_addr = BASE + 32'(r);
        tick();
    endtask

    task automatic rd_model(input logic [1:0] r);
        rd_exp(r, model_read(r));
    endtask

    task automatic pulse(input logic [N-1:0] v);
        irq = v;
        tick();
        irq = '0;
    endtask

    initial begin
        int r;
        #1;
        tick(); tick();
        mon_on = 1;
        reset_n = 1;
        tick(); tick();
        for (int i = 0; i < 4; i++) rd_exp(2'(i), 32'h0);
        // single line service
        wr(BASE + 0, 32'h05);
        pulse(8'h04);
        rd_exp(1, 32'h04);
        tick();
        wr(ACK, 0);
        rd_exp(2, 32'h8000_0002);
        rd_exp(1, 32'h0);
        wr(BASE + 3, 0);
        rd_exp(2, 32'h0);
        // simultaneous edges: lowest index first
        pulse(8'h05);
        tick(); tick();
        wr(ACK, 0);
        rd_exp(2, 32'h8000_0000);
        rd_exp(1, 32'h04);
        wr(BASE + 3, 0);
        tick(); tick();
        wr(ACK, 0);
        rd_exp(2, 32'h8000_0002);
        wr(BASE + 3, 0);
        // masked line becomes visible once enabled
        wr(BASE + 0, 32'h0);
        pulse(8'h08);
        rd_exp(1, 32'h08);
        tick();
        wr(BASE + 0, 32'h08);
        tick(); tick();
        wr(ACK, 0);
        rd_exp(2, 32'h8000_0003);
        wr(BASE + 3, 0);
        rd_exp(1, 32'h0);
        // retract via W1C, then W1C racing a new edge
        wr(BASE + 0, 32'h04);
        pulse(8'h04);
        tick();
        wr(BASE + 1, 32'h04);
        tick();
        rd_exp(1, 32'h0);
        irq = 8'h04;
        wr(BASE + 1, 32'h04);
        irq = '0;
        rd_exp(1, 32'h04);
        tick(); tick();
        // reset while trap is requested
        reset_n = 0;
        tick();
        reset_n = 1;
        for (int i = 0; i < 4; i++) rd_exp(2'(i), 32'h0);
        // random traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) irq[$urandom_range(0, N - 1)] ^= 1'b1;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset_n = 0;
                tick();
                reset_n = 1;
            end else if (r < 22) rd_model(2'($urandom_range(0, 3)));
            else if (r < 30) wr(BASE + 0, $urandom);
            else if (r < 35) wr(BASE + 1, $urandom);
            else if (r < 47) wr(ACK, $urandom);
            else if (r < 54) wr(BASE + 3, $urandom);
            else if (r < 57) wr(BASE + 2, $urandom);
            else tick();
        end
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
